// File: rtl/banked_regfile_if.sv
// banked_regfile_if: read/write/bank-control bus of the banked register file (rev 1.0)
`default_nettype none

interface banked_regfile_if #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);
  logic [NUM_READ*ADDR_W-1:0] read_register;
  logic [NUM_READ*WIDTH-1:0]  read_data;
  logic [ADDR_W-1:0]          write_register0;
  logic [WIDTH-1:0]           write_data0;
  logic                       reg_write0;
  logic [ADDR_W-1:0]          write_register1;
  logic [WIDTH-1:0]           write_data1;
  logic                       reg_write1;
  logic                       save_req;
  logic                       restore_req;
  logic                       bank_busy;
  logic                       bank_done;

  modport master (
    output read_register, write_register0, write_data0, reg_write0,
           write_register1, write_data1, reg_write1, save_req, restore_req,
    input  read_data, bank_busy, bank_done
  );

  modport slave (
    input  read_register, write_register0, write_data0, reg_write0,
           write_register1, write_data1, reg_write1, save_req, restore_req,
    output read_data, bank_busy, bank_done
  );
endinterface

`default_nettype wire

// File: rtl/banked_regfile.sv
// banked_regfile: multi-read, dual-write register file with shadow bank save/restore (rev 1.0)
`default_nettype none

module banked_regfile #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  parameter logic [DEPTH*WIDTH-1:0] RESET_TABLE =
      ((DEPTH*WIDTH)'(256) << (0*WIDTH))  | ((DEPTH*WIDTH)'(16)  << (3*WIDTH))  |
      ((DEPTH*WIDTH)'(4)   << (5*WIDTH))  | ((DEPTH*WIDTH)'(17)  << (12*WIDTH)) |
      ((DEPTH*WIDTH)'(129) << (15*WIDTH)) | ((DEPTH*WIDTH)'(10)  << (19*WIDTH))
) (
  input  logic              clk,
  input  logic              rst_n,
  banked_regfile_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } state_t;

  state_t                     state;
  logic [ADDR_W-1:0]          idx;
  logic                       busy;
  logic                       done;
  logic [WIDTH-1:0]           primary [DEPTH];
  logic [WIDTH-1:0]           shadow  [DEPTH];
  logic [NUM_READ*WIDTH-1:0]  rd_data;

  logic [NUM_READ*ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0]          wr_addr0, wr_addr1;
  logic [WIDTH-1:0]           wr_data0, wr_data1;
  logic                       we0, we1;

  assign rd_addr  = bus.read_register;
  assign wr_addr0 = bus.write_register0;
  assign wr_addr1 = bus.write_register1;
  assign wr_data0 = bus.write_data0;
  assign wr_data1 = bus.write_data1;
  // The restore sequence owns the primary array, so architectural writes are discarded.
  assign we0 = bus.reg_write0 && (state != RESTORE);
  assign we1 = bus.reg_write1 && (state != RESTORE);

  assign bus.read_data = rd_data;
  assign bus.bank_busy = busy;
  assign bus.bank_done = done;

  function automatic logic [WIDTH-1:0] fwd(input logic [ADDR_W-1:0] a,
                                           input logic [WIDTH-1:0]  cur);
    if (we1 && (wr_addr1 == a)) return wr_data1;
    if (we0 && (wr_addr0 == a)) return wr_data0;
    return cur;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) primary[i] <= RESET_TABLE[i*WIDTH +: WIDTH];
    end else if (state == RESTORE) begin
      primary[idx] <= shadow[idx];
    end else begin
      if (we0) primary[wr_addr0] <= wr_data0;
      if (we1) primary[wr_addr1] <= wr_data1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else if (state == SAVE) begin
      shadow[idx] <= fwd(idx, primary[idx]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      for (int k = 0; k < NUM_READ; k++) begin
        if (BYPASS != 0)
          rd_data[k*WIDTH +: WIDTH] <= fwd(rd_addr[k*ADDR_W +: ADDR_W],
                                           primary[rd_addr[k*ADDR_W +: ADDR_W]]);
        else
          rd_data[k*WIDTH +: WIDTH] <= primary[rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.save_req) begin
            state <= SAVE;
            idx   <= '0;
            busy  <= 1'b1;
          end else if (bus.restore_req) begin
            state <= RESTORE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SAVE, RESTORE: begin
          idx <= ADDR_W'(idx + 1'b1);
          if (idx == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: directed scoreboard bench for BYPASS=1 and BYPASS=0 instances
`default_nettype none

module tb_banked_regfile;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  banked_regfile_if #(.WIDTH(W), .ADDR_W(AW), .NUM_READ(NR)) bus1 ();
  banked_regfile_if #(.WIDTH(W), .ADDR_W(AW), .NUM_READ(NR)) bus0 ();

  banked_regfile #(.WIDTH(W), .DEPTH(D), .NUM_READ(NR), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  banked_regfile #(.WIDTH(W), .DEPTH(D), .NUM_READ(NR), .BYPASS(0)) u_dut_nobyp (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  typedef struct {
    int          inst;
    int          port;
    logic [W-1:0] val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  localparam logic [W-1:0] NEG354 = W'(-354);

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic push(input int inst, input int port, input logic [W-1:0] val, input string tag);
    exp_t e;
    e.inst = inst; e.port = port; e.val = val; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic pop_all();
    exp_t e;
    logic [W-1:0] got;
    while (q.size() > 0) begin
      e = q.pop_front();
      got = (e.inst == 1) ? bus1.read_data[e.port*W +: W] : bus0.read_data[e.port*W +: W];
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_check();
    tick();
    pop_all();
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus1.read_register = {a1, a0};
    bus0.read_register = {a1, a0};
  endtask

  task automatic set_wr(input logic e0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                        input logic e1, input logic [AW-1:0] a1, input logic [W-1:0] d1);
    bus1.reg_write0 = e0; bus1.write_register0 = a0; bus1.write_data0 = d0;
    bus1.reg_write1 = e1; bus1.write_register1 = a1; bus1.write_data1 = d1;
    bus0.reg_write0 = e0; bus0.write_register0 = a0; bus0.write_data0 = d0;
    bus0.reg_write1 = e1; bus0.write_register1 = a1; bus0.write_data1 = d1;
  endtask

  task automatic set_req(input logic sv, input logic rs);
    bus1.save_req = sv; bus1.restore_req = rs;
    bus0.save_req = sv; bus0.restore_req = rs;
  endtask

  task automatic push_both(input int port, input logic [W-1:0] val, input string tag);
    push(1, port, val, {tag, "_byp"});
    push(0, port, val, {tag, "_nobyp"});
  endtask

  // Observes one bank operation for 40 samples starting right after the request edge.
  task automatic watch_bank(input string tag, input bit mid_write);
    int busy_cnt = 0;
    int done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus1.bank_busy) busy_cnt++;
      if (bus1.bank_done) done_cnt++;
      if (mid_write && i == 5) begin
        set_wr(1'b1, 5'd3, W'(99), 1'b0, 5'd0, '0);
        set_req(1'b1, 1'b0);
      end
      if (mid_write && i == 6) begin
        set_wr(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        set_req(1'b0, 1'b0);
      end
      tick();
    end
    chk({tag, "_busy_cycles"}, W'(busy_cnt), W'(D));
    chk({tag, "_done_pulses"}, W'(done_cnt), W'(1));
  endtask

  initial begin
    set_rd(5'd0, 5'd0);
    set_wr(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    set_req(1'b0, 1'b0);

    // Reset state
    tick(); tick();
    chk("reset_rd_byp",    bus1.read_data[W-1:0], '0);
    chk("reset_rd_nobyp",  bus0.read_data[2*W-1:W], '0);
    chk("reset_busy",      W'(bus1.bank_busy), '0);
    chk("reset_done",      W'(bus1.bank_done), '0);
    rst_n = 1'b1;

    // Reset table
    set_rd(5'd0, 5'd5);   push_both(0, W'(256), "rt_r0");  push_both(1, W'(4),  "rt_r5");  tick_check();
    set_rd(5'd3, 5'd19);  push_both(0, W'(16),  "rt_r3");  push_both(1, W'(10), "rt_r19"); tick_check();
    set_rd(5'd15, 5'd12); push_both(0, W'(129), "rt_r15"); push_both(1, W'(17), "rt_r12"); tick_check();

    // Port 1 wins on an address collision
    set_rd(5'd7, 5'd9);
    set_wr(1'b1, 5'd7, W'(55), 1'b1, 5'd7, NEG354);
    push(1, 0, NEG354, "prio_same_edge_byp");
    push(0, 0, W'(0),  "prio_same_edge_nobyp");
    tick_check();
    set_wr(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    push_both(0, NEG354, "prio_r7");
    tick_check();

    // Two different addresses written together
    set_wr(1'b1, 5'd7, W'(55), 1'b1, 5'd9, W'(23456));
    push(1, 0, W'(55), "dual_r7_byp");   push(1, 1, W'(23456), "dual_r9_byp");
    push(0, 0, NEG354, "dual_r7_nobyp"); push(0, 1, W'(0),     "dual_r9_nobyp");
    tick_check();
    set_wr(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    push_both(0, W'(55), "dual_r7"); push_both(1, W'(23456), "dual_r9");
    tick_check();

    // Bypass vs. no bypass
    set_rd(5'd15, 5'd12);
    set_wr(1'b1, 5'd15, NEG354, 1'b0, 5'd0, '0);
    push(1, 0, NEG354, "bypass_byp"); push(0, 0, W'(129), "bypass_nobyp");
    push_both(1, W'(17), "bypass_r12");
    tick_check();
    set_wr(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    push_both(0, NEG354, "bypass_next");
    tick_check();

    // Save the bank
    set_req(1'b1, 1'b0);
    tick();
    set_req(1'b0, 1'b0);
    watch_bank("save", 1'b0);

    // Overwrite, then restore
    set_wr(1'b1, 5'd0, W'(1), 1'b1, 5'd31, W'(2));
    tick();
    set_wr(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    set_rd(5'd0, 5'd31);
    push_both(0, W'(1), "ovw_r0"); push_both(1, W'(2), "ovw_r31");
    tick_check();
    set_req(1'b0, 1'b1);
    tick();
    set_req(1'b0, 1'b0);
    watch_bank("restore", 1'b1);
    set_rd(5'd0, 5'd31);
    push_both(0, W'(256), "rest_r0"); push_both(1, W'(0), "rest_r31");
    tick_check();
    set_rd(5'd3, 5'd15);
    push_both(0, W'(16), "rest_r3_drop"); push_both(1, NEG354, "rest_r15");
    tick_check();

    // Reset in the middle of a save
    set_req(1'b1, 1'b0);
    tick();
    set_req(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("midsave_busy", W'(bus1.bank_busy), W'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",     W'(bus1.bank_busy), '0);
    chk("midrst_rd_byp",   bus1.read_data[W-1:0], '0);
    chk("midrst_rd_nobyp", bus0.read_data[2*W-1:W], '0);
    tick();
    chk("midrst_done", W'(bus1.bank_done), '0);
    rst_n = 1'b1;
    set_rd(5'd0, 5'd31);
    push_both(0, W'(256), "post_rst_r0"); push_both(1, W'(0), "post_rst_r31");
    tick_check();
    set_req(1'b0, 1'b1);
    tick();
    set_req(1'b0, 1'b0);
    watch_bank("zero_restore", 1'b0);
    set_rd(5'd0, 5'd5);
    push_both(0, W'(0), "zr_r0"); push_both(1, W'(0), "zr_r5");
    tick_check();
    set_rd(5'd3, 5'd19);
    push_both(0, W'(0), "zr_r3"); push_both(1, W'(0), "zr_r19");
    tick_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

`default_nettype wire
